// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson (twisted-ring) counter family.
// Holds the width ceiling and the legality / phase helpers used by the
// counter and by any other block that needs to interpret a Johnson state.
package johnson_pkg;

  localparam int MAX_WIDTH   = 16;
  localparam int PHASE_MAX_W = $clog2(2 * MAX_WIDTH);

  // Mask of k ones in the least significant bits, k = 0..MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] johnson_low_ones(input int k);
    logic [MAX_WIDTH:0] t;
    t = ({{MAX_WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
    return t[MAX_WIDTH-1:0];
  endfunction

  // A state is legal if it is k LSB ones (k = 0..width) or m MSB ones with
  // zeros below (m = 1..width-1). Bits above width must be zero.
  function automatic logic johnson_is_legal(input logic [MAX_WIDTH-1:0] state,
                                            input int width);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k <= MAX_WIDTH; k++) begin
      if (k <= width) begin
        if (state == johnson_low_ones(k)) ok = 1'b1;
      end
      if (k >= 1 && k < width) begin
        if (state == (johnson_low_ones(width) & ~johnson_low_ones(width - k)))
          ok = 1'b1;
      end
    end
    return ok;
  endfunction

  // Phase index of a state: k LSB ones -> k, m MSB ones -> 2*width-m.
  // Illegal states decode to phase 0.
  function automatic logic [PHASE_MAX_W-1:0] johnson_phase(
      input logic [MAX_WIDTH-1:0] state, input int width);
    logic [PHASE_MAX_W-1:0] ph;
    ph = '0;
    for (int k = 0; k <= MAX_WIDTH; k++) begin
      if (k <= width) begin
        if (state == johnson_low_ones(k)) ph = PHASE_MAX_W'(k);
      end
      if (k >= 1 && k < width) begin
        if (state == (johnson_low_ones(width) & ~johnson_low_ones(width - k)))
          ph = PHASE_MAX_W'(2 * width - k);
      end
    end
    return ph;
  endfunction

endpackage

// File: rtl/johnson_counter_gen_phase_decode.sv
// Combinational phase decoder for a Johnson counter state.
// Produces a binary phase index and its one-hot decode; illegal states
// give phase 0 and an all-zero one-hot vector so consumers see no enable.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh
);

  logic [MAX_WIDTH-1:0] q_ext;
  logic                 q_legal;

  assign q_ext   = MAX_WIDTH'(q);
  assign q_legal = johnson_is_legal(q_ext, WIDTH);
  assign phase   = PW'(johnson_phase(q_ext, WIDTH));

  // One comparator per phase; gated by legality so illegal states light nothing.
  generate
    for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_oh
      assign phase_oh[gi] = q_legal && (phase == PW'(gi));
    end
  endgenerate

endmodule

// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson counter with enable, direction, synchronous clear,
// parallel load, decoded phase outputs and a registered wrap pulse.
// Build option: JOHNSON_SELF_CORRECT_EN adds illegal-state recovery
// (illegal q or illegal load value forces state 0 and sets sticky err).
module johnson_counter_gen
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh,
  output logic               wrap,
  output logic               err
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] step_val;
  logic             step_taken;
  logic             wrap_reg;
  logic             wrap_next;

`ifdef JOHNSON_SELF_CORRECT_EN
  logic err_reg;
  logic err_next;
  logic err_set;
  logic q_legal;
  logic load_legal;

  assign q_legal    = johnson_is_legal(MAX_WIDTH'(q_reg), WIDTH);
  assign load_legal = johnson_is_legal(MAX_WIDTH'(load_val), WIDTH);
`endif

  // Single shift step in the selected direction; reverse is the exact inverse.
  always_comb begin
    if (dir) step_val = {~q_reg[0], q_reg[WIDTH-1:1]};
    else     step_val = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
  end

  // Next-state mux: clr beats recovery beats load beats en; otherwise hold.
  always_comb begin
    q_next     = q_reg;
    step_taken = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
    err_set    = 1'b0;
`endif
    if (clr) begin
      q_next = '0;
    end
`ifdef JOHNSON_SELF_CORRECT_EN
    else if (!q_legal) begin
      q_next  = '0;
      err_set = 1'b1;
    end
    else if (load) begin
      if (load_legal) begin
        q_next = load_val;
      end else begin
        q_next  = '0;
        err_set = 1'b1;
      end
    end
`else
    else if (load) begin
      q_next = load_val;
    end
`endif
    else if (en) begin
      q_next     = step_val;
      step_taken = 1'b1;
    end
  end

  // Wrap only when a genuine count step lands on the all-zero state.
  always_comb begin
    wrap_next = step_taken && (step_val == '0);
  end

  // State and wrap registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

`ifdef JOHNSON_SELF_CORRECT_EN
  // Sticky error: set on any recovery, cleared only by clr (or reset).
  always_comb begin
    if (clr) err_next = 1'b0;
    else     err_next = err_reg | err_set;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign q    = q_reg;
  assign wrap = wrap_reg;

  johnson_phase_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .q        (q_reg),
    .phase    (phase),
    .phase_oh (phase_oh)
  );

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Directed bench for johnson_counter_gen (WIDTH 4, 2 and 16 instances).
// Expected values come from a phase-index model and are queued per step.
module tb_johnson_counter_gen;

  localparam int W = 4;

`ifdef JOHNSON_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic         en = 0, dir = 0, clr = 0, load = 0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q4;
  logic [2:0]   ph4;
  logic [7:0]   oh4;
  logic         wrap4, err4;

  // WIDTH=2 instance
  logic       en2 = 0;
  logic [1:0] q2;
  logic [1:0] ph2;
  logic [3:0] oh2;
  logic       wrap2, err2;

  // WIDTH=16 instance
  logic        en16 = 0;
  logic [15:0] q16;
  logic [4:0]  ph16;
  logic [31:0] oh16;
  logic        wrap16, err16;

  johnson_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .q(q4), .phase(ph4), .phase_oh(oh4),
    .wrap(wrap4), .err(err4));

  johnson_counter_gen #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .dir(1'b0), .clr(1'b0), .load(1'b0),
    .load_val(2'b00), .q(q2), .phase(ph2), .phase_oh(oh2),
    .wrap(wrap2), .err(err2));

  johnson_counter_gen #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .dir(1'b0), .clr(1'b0), .load(1'b0),
    .load_val(16'h0000), .q(q16), .phase(ph16), .phase_oh(oh16),
    .wrap(wrap16), .err(err16));

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [2:0]   phase;
    logic [7:0]   oh;
    logic         wrap;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq = '0;
  logic         merr = 1'b0;

  // State for phase p of the W-bit ring.
  function automatic logic [W-1:0] m_state(input int p);
    int m;
    if (p <= W) return W'((1 << p) - 1);
    m = 2 * W - p;
    return W'(((1 << W) - 1) ^ ((1 << (W - m)) - 1));
  endfunction

  // Phase of a state by search over the ring; -1 if not on the ring.
  function automatic int m_find(input logic [W-1:0] s);
    for (int p = 0; p < 2 * W; p++)
      if (m_state(p) == s) return p;
    return -1;
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, what, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic w);
    exp_t x;
    int p;
    p = m_find(mq);
    x.tag   = tag;
    x.q     = mq;
    x.phase = (p < 0) ? 3'd0 : 3'(p);
    x.oh    = (p < 0) ? 8'h00 : (8'h01 << p);
    x.wrap  = w;
    x.err   = merr;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed 0 entries expected 1");
      return;
    end
    x = sb.pop_front();
    cmp(x.tag, "q",     32'(q4),    32'(x.q));
    cmp(x.tag, "phase", 32'(ph4),   32'(x.phase));
    cmp(x.tag, "oh",    32'(oh4),   32'(x.oh));
    cmp(x.tag, "wrap",  32'(wrap4), 32'(x.wrap));
    cmp(x.tag, "err",   32'(err4),  32'(x.err));
  endtask

  // Update model, queue expectation, drive one cycle, compare.
  task automatic step4(input string tag, input logic e, input logic d,
                       input logic c, input logic l, input logic [W-1:0] lv);
    int p;
    logic w;
    w = 1'b0;
    if (c) begin
      mq = '0; merr = 1'b0;
    end else if (SC && m_find(mq) < 0) begin
      mq = '0; merr = 1'b1;
    end else if (l) begin
      if (SC && m_find(lv) < 0) begin
        mq = '0; merr = 1'b1;
      end else begin
        mq = lv;
      end
    end else if (e) begin
      p = m_find(mq);
      if (p < 0) begin
        mq = d ? {~mq[0], mq[W-1:1]} : {mq[W-2:0], ~mq[W-1]};
      end else begin
        p  = d ? (p + 2 * W - 1) % (2 * W) : (p + 1) % (2 * W);
        mq = m_state(p);
        w  = (p == 0);
      end
    end
    push_exp(tag, w);
    @(negedge clk);
    en = e; dir = d; clr = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq = '0; merr = 1'b0;
    push_exp("reset", 1'b0);
    #1;
    check_out();

    // Forward 9 steps: 0001..1000,0000,0001 with wrap at 0000
    for (int i = 0; i < 9; i++) step4("fwd", 1, 0, 0, 0, '0);

    // Reverse back to 0000 (wrap in reverse), then a full reverse period
    step4("rev0", 1, 1, 0, 0, '0);
    for (int i = 0; i < 8; i++) step4("rev", 1, 1, 0, 0, '0);

    // Load beats en; then step, hold, step
    step4("load_en", 1, 0, 0, 1, 4'b0111);
    step4("post_load", 1, 0, 0, 0, '0);
    step4("hold", 0, 0, 0, 0, '0);
    step4("step_1110", 1, 0, 0, 0, '0);
    // clr beats load and en
    step4("clr_all", 1, 0, 1, 1, 4'b0011);

    // Illegal load value, then a step, then clear
    step4("ill_load", 0, 0, 0, 1, 4'b0101);
    step4("ill_step", 1, 0, 0, 0, '0);
    step4("ill_clr", 0, 0, 1, 0, '0);

    // Count to 1100 then assert reset asynchronously
    for (int i = 0; i < 6; i++) step4("to_1100", 1, 0, 0, 0, '0);
    cmp("pre_rst", "q", 32'(q4), 32'(4'b1100));
    #2;
    reset = 1'b1; en = 0; dir = 0; clr = 0; load = 0;
    #1;
    cmp("async_rst", "q", 32'(q4), 32'(4'b0000));
    cmp("async_rst", "wrap", 32'(wrap4), 32'(1'b0));
    cmp("async_rst", "oh", 32'(oh4), 32'(8'h01));
    @(negedge clk);
    reset = 1'b0;
    mq = '0; merr = 1'b0;

    // Land on 0000 with wrap high, then reset must drop wrap at once
    step4("rev_1000", 1, 1, 0, 0, '0);
    step4("fwd_wrap", 1, 0, 0, 0, '0);
    #2;
    reset = 1'b1; en = 0; dir = 0;
    #1;
    cmp("async_wrap", "wrap", 32'(wrap4), 32'(1'b0));
    cmp("async_wrap", "q", 32'(q4), 32'(4'b0000));
    @(negedge clk);
    reset = 1'b0;
    mq = '0; merr = 1'b0;

    // WIDTH=2: period 4
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      en2 = 1'b1;
      @(posedge clk);
      #1;
      cmp("w2", "phase", 32'(ph2), 32'(k % 4));
      cmp("w2", "wrap", 32'(wrap2), 32'(k == 4));
    end
    @(negedge clk);
    en2 = 1'b0;
    cmp("w2_end", "q", 32'(q2), 32'(2'b00));

    // WIDTH=16: period 32
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      en16 = 1'b1;
      @(posedge clk);
      #1;
      cmp("w16", "phase", 32'(ph16), 32'(k % 32));
      cmp("w16", "wrap", 32'(wrap16), 32'(k == 32));
      if (k == 16) cmp("w16_full", "q", 32'(q16), 32'(16'hFFFF));
    end
    @(negedge clk);
    en16 = 1'b0;
    cmp("w16_end", "q", 32'(q16), 32'(16'h0000));
    cmp("w16_end", "oh", oh16, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_counter_gen.md
# johnson_counter_gen

Parametrised Johnson (twisted-ring) counter for sequence and phase generation. It extends the fixed 4-bit shift-register counter with:
- configurable width;
- enable, direction control, synchronous clear and parallel load;
- decoded phase outputs and a wrap pulse.

Optional illegal-state self-correction is compiled in by macro. It is used wherever the design needs glitch-free multi-phase enables or small modulo-2·WIDTH sequencing.

## Interface
- WIDTH, 4, number of state flops; legal range 2..16; sequence length 2·WIDTH
- PW, $clog2(2·WIDTH), width of phase index (derived, not overridden)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; clock clk
- en  in  1  advance one step this cycle
- dir  in  1  0 = forward, 1 = reverse
- clr  in  1  synchronous clear to all-zero state
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value written on load
- q  out  WIDTH  counter state
- phase  out  PW  index 0..2·WIDTH-1 of current state
- phase_oh  out  2·WIDTH  one-hot decode of phase
- wrap  out  1  one-cycle pulse when a count step lands on state 0
- err  out  1  sticky illegal-state flag (self-correct build only)

## Operation
- Forward step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. WIDTH=4 gives 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- Reverse step: q <= {~q[0], q[WIDTH-1:1]}. This is the exact inverse sequence, so 0000→1000.
- Priority each cycle: clr > load > en. When none is active, q holds.
- Legal states: k LSB ones, k=0..WIDTH (phase k); or m MSB ones with zeros below, m=1..WIDTH-1 (phase 2·WIDTH-m).
- phase and phase_oh are combinational decodes of q. For an illegal q: phase = 0 and phase_oh = 0.
- wrap is registered. It is 1 in the cycle after an en step whose next state is 0, with clr=0 and load=0. Reaching 0 via reset, clr or load never asserts wrap. wrap is 1 in both directions.
- dir may change on any cycle; it takes effect on the next en step with no extra latency.
- load_val is written unmodified, unless the self-correct feature intervenes (see Configuration).

## Timing
- Reset values: q=0, phase=0, phase_oh=1 (bit 0), wrap=0, err=0.
- Reset is asynchronous assert and synchronous deassert at the system level. The first en step can occur on the first rising edge with reset low.
- Latency: one clock from en/clr/load to q. phase and phase_oh follow q combinationally in the same cycle. wrap coincides with q=0.
- Throughput: one step per cycle with en held high. The full period is 2·WIDTH cycles.
- Simultaneous clr+load+en: clr wins, q=0, wrap=0.
- Simultaneous load+en: the load value is taken and no step occurs.
- Reset mid-sequence: q returns to 0 immediately and wrap drops immediately. Counting restarts from phase 0.

## Configuration
- JOHNSON_SELF_CORRECT_EN defined:
  - Each cycle, an illegal q forces the next q to 0 and sets err. This applies regardless of en, and clr still has priority.
  - A load of an illegal load_val writes 0 and sets err.
  - err clears only on reset or clr.
- Not defined:
  - No legality check; err is tied 0.
  - Illegal values are loaded as-is and circulate in their own ring.
  - phase and phase_oh still decode illegal states as 0 and all-zero.

## Structure
- Package johnson_pkg holds:
  - MAX_WIDTH=16;
  - function johnson_is_legal(state, width);
  - function johnson_phase(state, width) returning the phase index.
- Sub-module johnson_phase_decode(WIDTH): q → phase, phase_oh. Purely combinational, reusable by other phase consumers.
- The top module holds the state register, next-state mux, wrap register and err logic.

## Test plan
- WIDTH=4, reset then en=1, dir=0 for 9 cycles:
  - q steps 0001,0011,0111,1111,1110,1100,1000,0000,0001;
  - phase 1..7,0,1;
  - wrap high only at the 0000 cycle.
- WIDTH=4, dir=1 from 0000 for 8 cycles: q = 1000,1100,1110,1111,0111,0011,0001,0000, with wrap at the final step.
- load=1, load_val=0111, en=1 same cycle: q=0111, phase=3, no step. Next en step: q=1111.
- clr=1, load=1, en=1 with q=1110: q=0000, wrap=0, phase_oh=0x01.
- Self-correct build, load_val=0101: q=0000, err=1. err holds through counting and clears on clr=1.
- Assert reset while q=1100 mid-count: q=0000 and wrap=0 immediately without a clock edge. WIDTH=2 and WIDTH=16 regressions confirm periods of 4 and 32.
